sample_frame_fifo: RTL and testbench

SAMPLE_FRAME_FIFO -- requirements
Module: sample_frame_fifo

---
 rtl/sample_frame_fifo.sv | 96 +++++++++
 tb/tb_sample_frame_fifo.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sample_frame_fifo.sv
// rtl/sample_frame_fifo.sv - sample FIFO with output frame marking; optional drop counter via SAMPLE_FRAME_FIFO_DROP_CNT_EN
module sample_frame_fifo #(
    parameter int W         = 16,
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       x_valid,
    output logic                       x_ready,
    input  logic [W-1:0]               x_data,
    output logic                       y_valid,
    input  logic                       y_ready,
    output logic [W-1:0]               y_data,
    output logic                       y_last,
    output logic [$clog2(DEPTH):0]     level,
    output logic [7:0]                 drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int FW = $clog2(FRAME_LEN);
    localparam logic [LW-1:0] FULL_LVL   = LW'(DEPTH);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_LEN - 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          push, pop;

    // Handshake flags depend only on registered occupancy.
    assign x_ready = (level_q != FULL_LVL);
    assign y_valid = (level_q != '0);
    assign y_data  = mem_q[rd_ptr_q];
    assign y_last  = y_valid && (frame_q == FRAME_LAST);
    assign level   = level_q;

    always_comb begin
        push     = x_valid && x_ready;
        pop      = y_valid && y_ready;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + LW'(push) - LW'(pop);
        frame_d  = frame_q;
        if (pop) begin
            frame_d = (frame_q == FRAME_LAST) ? '0 : frame_q + FW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            frame_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            frame_q  <= frame_d;
        end
    end

    // Storage is not cleared on reset; the pointers make old contents unreachable.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= x_data;
        end
    end

`ifdef SAMPLE_FRAME_FIFO_DROP_CNT_EN
    logic [7:0] drop_q, drop_d;

    always_comb begin
        drop_d = drop_q;
        if (x_valid && !x_ready && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_sample_frame_fifo.sv
// tb/tb_sample_frame_fifo.sv - randomized and directed bench for sample_frame_fifo against a queue model
module tb_sample_frame_fifo;

    localparam int W         = 16;
    localparam int DEPTH     = 16;
    localparam int FRAME_LEN = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    x_valid;
    logic                    x_ready;
    logic [W-1:0]            x_data;
    logic                    y_valid;
    logic                    y_ready;
    logic [W-1:0]            y_data;
    logic                    y_last;
    logic [$clog2(DEPTH):0]  level;
    logic [7:0]              drop_count;

    sample_frame_fifo #(.W(W), .DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .x_valid    (x_valid),
        .x_ready    (x_ready),
        .x_data     (x_data),
        .y_valid    (y_valid),
        .y_ready    (y_ready),
        .y_data     (y_data),
        .y_last     (y_last),
        .level      (level),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] model_q[$];
    int pos   = 0;
    int drops = 0;
    int last_seen = 0;
    int pops_seen = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic xv, input logic [W-1:0] xd, input logic yr);
        bit full, push, pop;
        reset   = rst;
        x_valid = xv;
        x_data  = xd;
        y_ready = yr;
        @(negedge clk);
        full = (model_q.size() == DEPTH);
        check("x_ready", 32'(x_ready), 32'(!full));
        check("y_valid", 32'(y_valid), 32'(model_q.size() != 0));
        if (model_q.size() != 0) check("y_data", 32'(y_data), 32'(model_q[0]));
        check("y_last", 32'(y_last), 32'(model_q.size() != 0 && pos == FRAME_LEN - 1));
        check("level", 32'(level), 32'(model_q.size()));
        check("drop_count", 32'(drop_count), 32'(drops));
        push = xv && !full;
        pop  = yr && (model_q.size() != 0);
        if (pop && !rst) begin
            pops_seen++;
            if (y_last) last_seen++;
        end
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            pos   = 0;
            drops = 0;
        end else begin
            if (pop) begin
                void'(model_q.pop_front());
                pos = (pos + 1) % FRAME_LEN;
            end
            if (push) model_q.push_back(xd);
`ifdef SAMPLE_FRAME_FIFO_DROP_CNT_EN
            if (xv && full && drops < 255) drops++;
`endif
        end
        #1;
    endtask

    initial begin
        int guard;
        reset = 1'b1; x_valid = 1'b0; x_data = '0; y_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, single push, hold under backpressure
        step(0, 1, 16'h1234, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 16'hdead, 0);

        // Fill to full, overflow attempt, drain in order
        step(1, 0, 0, 0);
        for (int i = 1; i <= 16; i++) step(0, 1, W'(i), 0);
        step(0, 1, 16'd17, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 0, 1);
        step(0, 0, 0, 0);

        // Full with simultaneous pop and push attempt
        for (int i = 1; i <= 16; i++) step(0, 1, W'(i + 32), 0);
        step(0, 1, 16'h0099, 1);
        step(0, 1, 16'h0100, 0);
        check("refill_level", 32'(level), 32'd16);

        // Steady push/pop at level 3 across pointer wraps
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, W'($urandom), 0);
        for (int i = 0; i < 40; i++) step(0, 1, W'($urandom), 1);
        check("steady_level", 32'(level), 32'd3);

        // Ten pops with random stalls
        step(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 1, W'($urandom), 0);
        pops_seen = 0; last_seen = 0; guard = 0;
        while (pops_seen < 10 && guard < 200) begin
            step(0, 0, 0, ($urandom_range(0, 2) != 0) && (pops_seen < 10));
            guard++;
        end
        check("pop10_done", 32'(pops_seen), 32'd10);
        check("pop10_lasts", 32'(last_seen), 32'd2);

        // Reset mid-frame restarts framing
        step(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 1, W'($urandom), 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(1, 1, 16'hbeef, 1);
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_yvalid", 32'(y_valid), 32'd0);
        pops_seen = 0; last_seen = 0;
        for (int i = 0; i < 4; i++) step(0, 1, W'($urandom), 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        check("midrst_lasts", 32'(last_seen), 32'd1);

        // Random traffic with varying fill bias and occasional reset
        for (int blk = 0; blk < 20; blk++) begin
            int pin, pout;
            pin  = $urandom_range(10, 90);
            pout = $urandom_range(10, 90);
            for (int i = 0; i < 80; i++) begin
                step($urandom_range(0, 199) == 0,
                     $urandom_range(0, 99) < pin,
                     W'($urandom),
                     $urandom_range(0, 99) < pout);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
